// File: rtl/sd_dec_pkg.sv
// Shared definitions for the sigma-delta CIC decimator.
//   SD_POS / SD_NEG : modulator symbol codes for +1 / -1 (others decode to 0)
//   sd_decode       : 2-bit symbol -> signed 2-bit value in {-1, 0, +1}
//   cic_acc_width   : accumulator width for a CIC of the given ratio and order
package sd_dec_pkg;

  localparam logic [1:0] SD_POS = 2'b01;
  localparam logic [1:0] SD_NEG = 2'b10;

  function automatic logic signed [1:0] sd_decode(input logic [1:0] sym);
    case (sym)
      SD_POS:  return 2'sb01;
      SD_NEG:  return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

  // Input magnitude is 1 (1 bit) plus sign, CIC gain is decim^order.
  function automatic int cic_acc_width(input int decim, input int order);
    return 2 + order * $clog2(decim);
  endfunction

endpackage

// File: rtl/sd_cic_comb.sv
// One CIC differentiator stage: dout = din - din_at_previous_enable.
//   clk, reset : clock, synchronous active-high reset (clears the delay)
//   en         : stage advances (delay captures din) on this cycle
//   din, dout  : stage input / combinational difference output
module sd_cic_comb #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] dly;

  // Modulo 2^WIDTH difference; wrap-around in the integrators cancels here.
  assign dout = din - dly;

  always_ff @(posedge clk) begin
    if (reset)   dly <= '0;
    else if (en) dly <= din;
  end

endmodule

// File: rtl/sd_cic_decimator.sv
// 3rd-order CIC decimator for the 2-bit sigma-delta symbol stream.
//   clk, reset  : clock, synchronous active-high reset
//   en          : sd_in is consumed on en=1 cycles; integrators/counter freeze otherwise
//   sd_in       : symbol 01=+1, 10=-1, 00/11=0
//   dout        : decimated sample (two's complement, ACC_WIDTH bits)
//   dout_valid  : dout holds an unconsumed sample
//   dout_ready  : consumer takes dout when dout_valid && dout_ready
//   overrun     : sticky, a result was dropped because dout was still full
module sd_cic_decimator
  import sd_dec_pkg::*;
#(
  parameter  int DECIM     = 64,
  parameter  int ORDER     = 3,
  localparam int ACC_WIDTH = cic_acc_width(DECIM, ORDER)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [1:0]           sd_in,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 overrun
);

  localparam int CW     = $clog2(DECIM);
  localparam int STAGES = 3;

  logic signed [1:0]                   xs;
  logic        [ACC_WIDTH-1:0]         x;
  logic        [STAGES-1:0][ACC_WIDTH-1:0] integ;
  logic        [STAGES:0][ACC_WIDTH-1:0]   stg;
  logic        [CW-1:0]                cnt;
  logic                                tick;

  assign xs = sd_decode(sd_in);
  assign x  = {{(ACC_WIDTH-2){xs[1]}}, xs};

  // Integrators: each stage adds the previous stage's old value, so the
  // chain is pipelined by one sample per stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      integ <= '0;
    end else if (en) begin
      integ[0] <= integ[0] + x;
      for (int k = 1; k < STAGES; k++)
        integ[k] <= integ[k] + integ[k-1];
    end
  end

  // DECIM is a power of two, so the counter wraps on its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= en && (cnt == CW'(DECIM - 1));
      if (en) cnt <= cnt + CW'(1);
    end
  end

  // Comb chain runs at the decimated rate, clocked by tick.
  assign stg[0] = integ[STAGES-1];

  for (genvar g = 0; g < STAGES; g++) begin : g_comb
    sd_cic_comb #(.WIDTH(ACC_WIDTH)) u_comb (
      .clk   (clk),
      .reset (reset),
      .en    (tick),
      .din   (stg[g]),
      .dout  (stg[g+1])
    );
  end

  // Output register: a new result may replace a sample that is being
  // accepted in the same cycle; otherwise a full register drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (tick) begin
      if (!dout_valid || dout_ready) begin
        dout       <= stg[STAGES];
        dout_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Directed bench for sd_cic_decimator (DECIM=64, ACC_WIDTH=20).
// DC +1 from reset gives I3(n)=C(n,3): outputs 41664, 216384, then 262144.
module tb_sd_cic_decimator;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  sd_in;
  logic [19:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        overrun;

  sd_cic_decimator #(.DECIM(64), .ORDER(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sd_in      (sd_in),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][1:0] pat;   // pat[i] used on en-cycle index i mod 4
    int              expv;  // settled output value
    string           nm;
  } vec_t;

  vec_t tbl [5];
  int   nerr = 0;
  int   nchk = 0;
  int   nstep;
  int   outs[$];
  int   ostep[$];

  task automatic chk(input string nm, input int got, input int expv);
    nchk++;
    if (got != expv) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
    end
  endtask

  // One clock; sample 1 time unit after the edge. Records accepted samples.
  task automatic step();
    @(posedge clk);
    #1;
    nstep++;
    if (dout_valid && dout_ready) begin
      outs.push_back(int'($signed(dout)));
      ostep.push_back(nstep);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    step();
    step();
    reset = 1'b0;
    nstep = 0;
    outs.delete();
    ostep.delete();
  endtask

  function automatic int sdout();
    return int'($signed(dout));
  endfunction

  initial begin
    reset = 1'b1; en = 1'b0; sd_in = 2'b00; dout_ready = 1'b1; nstep = 0;

    tbl[0] = '{pat: {2'b01, 2'b01, 2'b01, 2'b01}, expv:  262144, nm: "dc_pos"};
    tbl[1] = '{pat: {2'b10, 2'b10, 2'b10, 2'b10}, expv: -262144, nm: "dc_neg"};
    tbl[2] = '{pat: {2'b11, 2'b00, 2'b11, 2'b00}, expv:       0, nm: "zero_codes"};
    tbl[3] = '{pat: {2'b10, 2'b01, 2'b10, 2'b01}, expv:       0, nm: "alternate"};
    tbl[4] = '{pat: {2'b10, 2'b00, 2'b01, 2'b01}, expv:   65536, nm: "quarter"};

    // ---- reset state ----
    reset = 1'b1;
    step(); step();
    chk("rst_dout",    sdout(),          0);
    chk("rst_valid",   int'(dout_valid), 0);
    chk("rst_overrun", int'(overrun),    0);

    // ---- table-driven continuous run, 4 blocks per pattern ----
    do_reset();
    dout_ready = 1'b1;
    en = 1'b1;
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < 256; i++) begin
        sd_in = tbl[p].pat[(p * 256 + i) % 4];
        step();
      end
    sd_in = 2'b00;
    step(); step();
    chk("stream_nout", outs.size(), 20);
    if (outs.size() >= 20) begin
      chk("stream_out0", outs[0], 41664);
      chk("stream_out1", outs[1], 216384);
      for (int k = 0; k < 20; k++)
        chk($sformatf("stream_step%0d", k), ostep[k], 65 + 64 * k);
      for (int p = 0; p < 5; p++) begin
        chk($sformatf("%s_a", tbl[p].nm), outs[4*p+2], tbl[p].expv);
        chk($sformatf("%s_b", tbl[p].nm), outs[4*p+3], tbl[p].expv);
      end
    end
    chk("stream_overrun", int'(overrun), 0);

    // ---- en toggling: same values, half rate ----
    do_reset();
    sd_in = 2'b01;
    for (int s = 0; s < 514; s++) begin
      en = (s % 2 == 0);
      step();
    end
    chk("half_nout", outs.size(), 4);
    if (outs.size() >= 4) begin
      chk("half_out0", outs[0], 41664);
      chk("half_out2", outs[2], 262144);
      chk("half_out3", outs[3], 262144);
      for (int k = 0; k < 4; k++)
        chk($sformatf("half_step%0d", k), ostep[k], 128 * (k + 1));
    end

    // ---- backpressure, accept-on-tick, drop, mid-block reset ----
    do_reset();
    dout_ready = 1'b0;
    en = 1'b1;
    sd_in = 2'b01;
    repeat (65) step();
    chk("bp_first_valid", int'(dout_valid), 1);
    chk("bp_first_dout",  sdout(), 41664);
    chk("bp_first_ovr",   int'(overrun), 0);
    repeat (35) step();
    chk("bp_hold_dout",   sdout(), 41664);
    chk("bp_hold_valid",  int'(dout_valid), 1);
    repeat (28) step();
    dout_ready = 1'b1;          // same cycle as the second tick
    step();
    dout_ready = 1'b0;
    chk("bp_swap_dout",   sdout(), 216384);
    chk("bp_swap_valid",  int'(dout_valid), 1);
    chk("bp_swap_ovr",    int'(overrun), 0);
    repeat (64) step();         // third tick finds the register full
    chk("bp_drop_dout",   sdout(), 216384);
    chk("bp_drop_valid",  int'(dout_valid), 1);
    chk("bp_drop_ovr",    int'(overrun), 1);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_dout",  sdout(), 0);
    chk("mrst_valid", int'(dout_valid), 0);
    chk("mrst_ovr",   int'(overrun), 0);
    dout_ready = 1'b1;
    begin
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 200) begin
        step();
        n++;
        if (dout_valid) seen = 1'b1;
      end
      chk("mrst_seen",    int'(seen), 1);
      chk("mrst_latency", n, 65);
      chk("mrst_dout1",   sdout(), 41664);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/sd_cic_decimator.md
Name: sd_cic_decimator

Overview:
Downstream consumer of the two-piece sigma-delta modulator's 2-bit sd_out stream. Decodes each symbol to a signed value in {-1, 0, +1} and runs a 3rd-order CIC decimator (integrators, decimate by DECIM, combs). Delivers multi-bit signed samples through a valid/ready output register. Feeds measurement and readback logic that checks modulator output against the programmed kin.

Parameters:
DECIM, 64, decimation ratio; power of two, minimum 4.
ORDER, 3, CIC order; fixed at 3, present for documentation and checking only.
ACC_WIDTH, 2+3*$clog2(DECIM) (=20), width of the internal accumulators and of dout; derived, never overridden.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  input sample strobe; sd_in is consumed only on cycles with en=1
sd_in  in  2  modulator symbol: 2'b01=+1, 2'b10=-1, 2'b00 and 2'b11 = 0
dout  out  ACC_WIDTH  signed decimated sample
dout_valid  out  1  dout holds an unconsumed sample
dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready
overrun  out  1  sticky: a result was dropped because the output register was still full

Behaviour:
- Reset (synchronous, active-high): integrators I1..I3, comb delays D1..D3, decimation counter, tick flag, dout, dout_valid and overrun all go to 0. Reset mid-operation discards all state, including a pending output.
- Decode: x = +1, -1 or 0, sign-extended to ACC_WIDTH.
- Integrators update only on en=1 cycles, pipelined and each using the old values: I1<=I1+x, I2<=I2+I1, I3<=I3+I2. All arithmetic is modulo 2^ACC_WIDTH. Wrap-around is required, with no saturation.
- Decimation counter: on each en=1 cycle it counts 0..DECIM-1 and wraps to 0. If count==DECIM-1 on an en=1 cycle (call it cycle T), the tick flag is 1 in cycle T+1. en=0 freezes the integrators and the counter.
- Comb stages update only in the cycle the tick flag is high (T+1):
  - c1=I3-D1, then D1<=I3
  - c2=c1-D2, then D2<=c1
  - c3=c2-D3, then D3<=c2
  - the result is c3; all arithmetic is modulo 2^ACC_WIDTH.
- Output register:
  - Result produced in T+1 with the register empty, or with dout_valid && dout_ready in that cycle: dout<=c3. dout_valid is high from T+2. Fixed latency is 2 cycles from the tick input cycle.
  - Result produced while dout_valid && !dout_ready: the new result is dropped, dout is unchanged, overrun<=1.
  - Handshake with no new result: dout_valid<=0.
  - dout holds stable while dout_valid=1 and not accepted.
- overrun clears only on reset.
- Gain: DC input +1 gives DECIM^3 (262144 for DECIM=64). The first two outputs after reset are transient. The third and later outputs are settled.

Decomposition:
- Package sd_dec_pkg:
  - symbol code localparams SD_POS=2'b01, SD_NEG=2'b10
  - function sd_decode(2-bit) returning a signed 2-bit value
  - function cic_acc_width(decim, order)
- Sub-module sd_cic_comb: one differentiator stage (width parameter, enable, in, out, delay register), instantiated 3 times. Integrators, counter and handshake stay in the top module.

Test Plan:
- Reset, then constant sd_in=2'b01 with en=1 and dout_ready=1 -> outputs 3 onward = 262144 (0x40000). dout_valid is a single-cycle pulse every 64 cycles, 2 cycles after each count==63 input.
- Constant 2'b10 -> settled outputs = -262144 (0xC0000). Then 2'b00 and 2'b11 -> outputs decay to 0 by the third output.
- Alternating 2'b01/2'b10 -> settled outputs = 0. Pattern (01,01,00,10) repeating -> settled outputs = 65536.
- en toggled 1/0 every cycle with constant +1 -> same output values as the first scenario, at half the rate. The counter does not advance on en=0 cycles.
- dout_ready=0 across two decimation ticks -> first sample held stable, second dropped, overrun=1. Raising dout_ready in the same cycle as a tick -> old sample accepted, new one loaded, overrun not newly set.
- Assert reset for 1 cycle mid-block with dout_valid=1 and overrun=1 -> next cycle dout=0, dout_valid=0, overrun=0, counter=0. The next output appears after exactly 64 en cycles + 2.
